usb_rx_decoder: RTL and testbench



---
 rtl/usb_rx_pkg.sv | 22 ++
 rtl/usb_rx_bit_timer.sv | 62 ++++++
 rtl/usb_rx_decoder.sv | 193 +++++++++++++++++++
 tb/tb_usb_rx_decoder.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_rx_pkg.sv
// usb_rx_pkg
//   Shared types and constants for the USB receive front-end.
//   state_t     : receive state machine encoding
//   SYNC_BYTE   : decoded value of a valid SYNC field (KJKJKJKK)
//   STUFF_LIMIT : run of 1s after which the transmitter inserts a 0
//   IDLE_BITS   : bit times of J needed to leave the error state

package usb_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    DATA,
    EOP,
    ERR_WAIT
  } state_t;

  localparam logic [7:0]  SYNC_BYTE   = 8'h80;
  localparam int unsigned STUFF_LIMIT = 6;
  localparam int unsigned IDLE_BITS   = 8;

endpackage

// File: rtl/usb_rx_bit_timer.sv
// usb_rx_bit_timer
//   Brings the raw D+/D- lines into the clk domain and recovers bit timing.
//   Ports:
//     clk, n_rst            : clock, asynchronous active-low reset
//     d_plus_i, d_minus_i   : raw asynchronous line inputs
//     sample_o              : one-cycle strobe at the bit sampling point
//     dp_s_o, dm_s_o        : synchronized line values (2 cycles late)
//     edge_o                : synchronized D+ changed this cycle

module usb_rx_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 8,
  parameter int unsigned SAMPLE_PT    = 3
) (
  input  logic clk,
  input  logic n_rst,
  input  logic d_plus_i,
  input  logic d_minus_i,
  output logic sample_o,
  output logic dp_s_o,
  output logic dm_s_o,
  output logic edge_o
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);

  logic [1:0]    dp_sync_q;
  logic [1:0]    dm_sync_q;
  logic          dp_prev_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign dp_s_o   = dp_sync_q[1];
  assign dm_s_o   = dm_sync_q[1];
  assign edge_o   = dp_sync_q[1] ^ dp_prev_q;
  assign sample_o = (cnt_q == CW'(SAMPLE_PT));

  // Every D+ transition re-centres the bit window so the sample point
  // tracks the transmitter even with small frequency offsets.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (edge_o || (cnt_q == CW'(CLKS_PER_BIT - 1))) begin
      cnt_d = '0;
    end
  end

  // Synchronizers power up in the idle J state so reset never looks like
  // the start of a packet.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      dp_sync_q <= 2'b11;
      dm_sync_q <= 2'b00;
      dp_prev_q <= 1'b1;
      cnt_q     <= '0;
    end else begin
      dp_sync_q <= {dp_sync_q[0], d_plus_i};
      dm_sync_q <= {dm_sync_q[0], d_minus_i};
      dp_prev_q <= dp_sync_q[1];
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: rtl/usb_rx_decoder.sv
// usb_rx_decoder
//   USB receive front-end: NRZI decode, bit unstuffing, SYNC/EOP checks and
//   byte delivery to the RX FIFO.
//   Ports:
//     clk, n_rst               : USB-domain clock, async active-low reset
//     d_plus_in, d_minus_in    : raw line inputs
//     fifo_full                : RX FIFO cannot accept a byte
//     rcv_data                 : decoded byte, valid with w_enable
//     w_enable                 : one-cycle FIFO write strobe
//     rcving                   : packet reception in progress
//     r_error                  : sticky packet error, cleared at next SYNC
//     eop_pulse                : one-cycle pulse on a clean end of packet

module usb_rx_decoder
  import usb_rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 8,
  parameter int unsigned SAMPLE_PT    = 3
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       d_plus_in,
  input  logic       d_minus_in,
  input  logic       fifo_full,
  output logic [7:0] rcv_data,
  output logic       w_enable,
  output logic       rcving,
  output logic       r_error,
  output logic       eop_pulse
);

  logic sample, dp_s, dm_s, line_edge;

  usb_rx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .SAMPLE_PT   (SAMPLE_PT)
  ) u_timer (
    .clk      (clk),
    .n_rst    (n_rst),
    .d_plus_i (d_plus_in),
    .d_minus_i(d_minus_in),
    .sample_o (sample),
    .dp_s_o   (dp_s),
    .dm_s_o   (dm_s),
    .edge_o   (line_edge)
  );

  state_t     state_q;
  logic [7:0] shift_q;
  logic [2:0] bit_cnt_q;
  logic [2:0] ones_q;
  logic       prev_q;
  logic       eop_se0_q;
  logic [3:0] idle_cnt_q;
  logic [7:0] rcv_data_q;
  logic       w_enable_q, rcving_q, r_error_q, eop_pulse_q;

  logic       se0, line_j, sync_start, nrzi_bit, stuff_hit;
  logic [7:0] byte_d;
  logic [2:0] ones_d;

  assign se0        = !dp_s && !dm_s;
  assign line_j     = dp_s && !dm_s;
  assign sync_start = line_edge && !dp_s && dm_s;
  assign nrzi_bit   = (dp_s == prev_q);
  assign byte_d     = {nrzi_bit, shift_q[7:1]};
  assign ones_d     = nrzi_bit ? (ones_q + 3'd1) : 3'd0;
  assign stuff_hit  = (ones_q == 3'(STUFF_LIMIT));

  assign rcv_data  = rcv_data_q;
  assign w_enable  = w_enable_q;
  assign rcving    = rcving_q;
  assign r_error   = r_error_q;
  assign eop_pulse = eop_pulse_q;

  // Receive state machine. The ones counter also runs through SYNC because
  // the trailing 1 of SYNC belongs to the stuffing run, as on the wire.
  // Overflow is judged on fifo_full at the sampling strobe of the 8th bit,
  // one cycle ahead of the registered write strobe.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      ones_q      <= '0;
      prev_q      <= 1'b1;
      eop_se0_q   <= 1'b0;
      idle_cnt_q  <= '0;
      rcv_data_q  <= '0;
      w_enable_q  <= 1'b0;
      rcving_q    <= 1'b0;
      r_error_q   <= 1'b0;
      eop_pulse_q <= 1'b0;
    end else begin
      w_enable_q  <= 1'b0;
      eop_pulse_q <= 1'b0;
      if (sample) begin
        prev_q <= dp_s;
      end

      case (state_q)
        IDLE: begin
          if (sync_start) begin
            state_q   <= SYNC;
            rcving_q  <= 1'b1;
            r_error_q <= 1'b0;
            bit_cnt_q <= '0;
            ones_q    <= '0;
            prev_q    <= 1'b1;
          end
        end

        SYNC: begin
          if (sample) begin
            shift_q   <= byte_d;
            ones_q    <= ones_d;
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (byte_d == SYNC_BYTE) begin
                state_q <= DATA;
              end else begin
                r_error_q  <= 1'b1;
                idle_cnt_q <= '0;
                state_q    <= ERR_WAIT;
              end
            end
          end
        end

        DATA: begin
          if (sample) begin
            if (se0) begin
              eop_se0_q <= 1'b0;
              state_q   <= EOP;
            end else if (stuff_hit) begin
              ones_q <= '0;
              if (nrzi_bit) begin
                r_error_q  <= 1'b1;
                idle_cnt_q <= '0;
                state_q    <= ERR_WAIT;
              end
            end else begin
              shift_q   <= byte_d;
              ones_q    <= ones_d;
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                if (fifo_full) begin
                  r_error_q <= 1'b1;
                end else begin
                  w_enable_q <= 1'b1;
                  rcv_data_q <= byte_d;
                end
              end
            end
          end
        end

        // First SE0 was seen in DATA; need one more SE0 then J.
        EOP: begin
          if (sample) begin
            if (!eop_se0_q && se0) begin
              eop_se0_q <= 1'b1;
            end else if (eop_se0_q && line_j && (bit_cnt_q == 3'd0)) begin
              rcving_q    <= 1'b0;
              eop_pulse_q <= !r_error_q;
              state_q     <= IDLE;
            end else begin
              r_error_q  <= 1'b1;
              idle_cnt_q <= '0;
              state_q    <= ERR_WAIT;
            end
          end
        end

        ERR_WAIT: begin
          if (sample) begin
            if (!line_j) begin
              idle_cnt_q <= '0;
            end else if (idle_cnt_q == 4'(IDLE_BITS - 1)) begin
              rcving_q <= 1'b0;
              state_q  <= IDLE;
            end else begin
              idle_cnt_q <= idle_cnt_q + 4'd1;
            end
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_rx_decoder.sv
// tb_usb_rx_decoder
//   Table-driven bench for usb_rx_decoder. A small transmitter model NRZI
//   encodes and bit-stuffs packets onto D+/D-; a monitor records every FIFO
//   write and end-of-packet pulse, and expected results come from the table
//   or the hand-written corner-case sequences.

module tb_usb_rx_decoder;

  localparam int CPB = 8;

  logic       clk;
  logic       n_rst;
  logic       d_plus_in;
  logic       d_minus_in;
  logic       fifo_full;
  logic [7:0] rcv_data;
  logic       w_enable;
  logic       rcving;
  logic       r_error;
  logic       eop_pulse;

  usb_rx_decoder #(
    .CLKS_PER_BIT(CPB),
    .SAMPLE_PT   (3)
  ) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .d_plus_in (d_plus_in),
    .d_minus_in(d_minus_in),
    .fifo_full (fifo_full),
    .rcv_data  (rcv_data),
    .w_enable  (w_enable),
    .rcving    (rcving),
    .r_error   (r_error),
    .eop_pulse (eop_pulse)
  );

  typedef struct {
    logic [7:0] b0;
    logic [7:0] b1;
    int         nBytes;
    logic [1:0] fullMask;
    int         expWrites;
    logic [7:0] exp0;
    logic [7:0] exp1;
    int         expEop;
    logic       expErr;
  } vec_t;

  vec_t       vecs[5];
  int         vecApplied  = 0;
  int         miscompares = 0;
  int         wrTotal     = 0;
  int         eopTotal    = 0;
  logic [7:0] gotBytes[$];
  logic       lineJ       = 1'b1;
  int         onesCnt     = 0;

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so a stuck run still ends with a visible failure.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  // Monitor: log every write strobe and end-of-packet pulse, sampled on the
  // falling edge away from the DUT's active edge.
  always @(negedge clk) begin
    if (w_enable) begin
      wrTotal++;
      gotBytes.push_back(rcv_data);
    end
    if (eop_pulse) begin
      eopTotal++;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecApplied++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive one line symbol for a full bit time.
  task automatic holdSym(input logic dp, input logic dm);
    @(negedge clk);
    d_plus_in  = dp;
    d_minus_in = dm;
    repeat (CPB - 1) @(negedge clk);
  endtask

  // NRZI: a 0 toggles the line, a 1 keeps it.
  task automatic sendNrzi(input logic b);
    if (!b) lineJ = !lineJ;
    holdSym(lineJ, !lineJ);
  endtask

  task automatic sendSync();
    lineJ = 1'b1;
    for (int i = 0; i < 8; i++) sendNrzi(i == 7);
    onesCnt = 1;
  endtask

  // LSB first, inserting a 0 after every six consecutive 1s.
  task automatic sendByte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) begin
      sendNrzi(v[i]);
      onesCnt = v[i] ? onesCnt + 1 : 0;
      if (onesCnt == 6) begin
        sendNrzi(1'b0);
        onesCnt = 0;
      end
    end
  endtask

  task automatic sendEop();
    holdSym(1'b0, 1'b0);
    holdSym(1'b0, 1'b0);
    lineJ = 1'b1;
    holdSym(1'b1, 1'b0);
  endtask

  task automatic idleBits(input int n);
    lineJ = 1'b1;
    repeat (n) holdSym(1'b1, 1'b0);
  endtask

  function automatic logic [31:0] byteAt(input int idx);
    if (gotBytes.size() > idx) return {24'h0, gotBytes[idx]};
    return 32'hDEAD;
  endfunction

  // Send one table packet and compare everything it should have produced.
  task automatic applyStimulus(input vec_t v, input int idx);
    int baseW, baseE, baseQ;
    baseW = wrTotal;
    baseE = eopTotal;
    baseQ = gotBytes.size();
    idleBits(2);
    sendSync();
    checkOutput($sformatf("v%0d_rcving_mid", idx), {31'h0, rcving}, 32'd1);
    if (v.nBytes >= 1) begin
      fifo_full = v.fullMask[0];
      sendByte(v.b0);
    end
    if (v.nBytes >= 2) begin
      fifo_full = v.fullMask[1];
      sendByte(v.b1);
    end
    fifo_full = 1'b0;
    sendEop();
    idleBits(2);
    checkOutput($sformatf("v%0d_writes", idx), wrTotal - baseW, v.expWrites);
    if (v.expWrites >= 1) checkOutput($sformatf("v%0d_byte0", idx), byteAt(baseQ), {24'h0, v.exp0});
    if (v.expWrites >= 2) checkOutput($sformatf("v%0d_byte1", idx), byteAt(baseQ + 1), {24'h0, v.exp1});
    checkOutput($sformatf("v%0d_eop", idx), eopTotal - baseE, v.expEop);
    checkOutput($sformatf("v%0d_r_error", idx), {31'h0, r_error}, {31'h0, v.expErr});
    checkOutput($sformatf("v%0d_rcving_end", idx), {31'h0, rcving}, 32'd0);
  endtask

  // Main test sequence.
  initial begin
    int baseW, baseE;

    vecs[0] = '{b0:8'hA5, b1:8'h3C, nBytes:2, fullMask:2'b00, expWrites:2, exp0:8'hA5, exp1:8'h3C, expEop:1, expErr:1'b0};
    vecs[1] = '{b0:8'hFF, b1:8'h01, nBytes:2, fullMask:2'b00, expWrites:2, exp0:8'hFF, exp1:8'h01, expEop:1, expErr:1'b0};
    vecs[2] = '{b0:8'hA5, b1:8'h3C, nBytes:2, fullMask:2'b10, expWrites:1, exp0:8'hA5, exp1:8'h00, expEop:0, expErr:1'b1};
    vecs[3] = '{b0:8'h00, b1:8'h00, nBytes:1, fullMask:2'b00, expWrites:1, exp0:8'h00, exp1:8'h00, expEop:1, expErr:1'b0};
    vecs[4] = '{b0:8'h7E, b1:8'h00, nBytes:1, fullMask:2'b00, expWrites:1, exp0:8'h7E, exp1:8'h00, expEop:1, expErr:1'b0};

    n_rst      = 1'b0;
    d_plus_in  = 1'b1;
    d_minus_in = 1'b0;
    fifo_full  = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("reset_rcv_data", {24'h0, rcv_data}, 32'h0);
    checkOutput("reset_w_enable", {31'h0, w_enable}, 32'h0);
    checkOutput("reset_rcving", {31'h0, rcving}, 32'h0);
    checkOutput("reset_r_error", {31'h0, r_error}, 32'h0);
    checkOutput("reset_eop_pulse", {31'h0, eop_pulse}, 32'h0);
    n_rst = 1'b1;

    for (int i = 0; i < 5; i++) applyStimulus(vecs[i], i);

    // Bad SYNC: KJKJKJKJ decodes as 8'h00.
    baseW = wrTotal;
    baseE = eopTotal;
    idleBits(2);
    lineJ = 1'b1;
    for (int i = 0; i < 8; i++) sendNrzi(1'b0);
    checkOutput("badsync_r_error", {31'h0, r_error}, 32'd1);
    checkOutput("badsync_rcving_wait", {31'h0, rcving}, 32'd1);
    idleBits(10);
    checkOutput("badsync_rcving_idle", {31'h0, rcving}, 32'd0);
    checkOutput("badsync_r_error_sticky", {31'h0, r_error}, 32'd1);
    checkOutput("badsync_writes", wrTotal - baseW, 32'd0);
    checkOutput("badsync_eop", eopTotal - baseE, 32'd0);

    // Stuff error: unstuffed run of 1s straight after SYNC.
    baseW = wrTotal;
    baseE = eopTotal;
    idleBits(2);
    sendSync();
    for (int i = 0; i < 7; i++) sendNrzi(1'b1);
    checkOutput("stufferr_r_error", {31'h0, r_error}, 32'd1);
    checkOutput("stufferr_rcving_wait", {31'h0, rcving}, 32'd1);
    idleBits(10);
    checkOutput("stufferr_rcving_idle", {31'h0, rcving}, 32'd0);
    checkOutput("stufferr_writes", wrTotal - baseW, 32'd0);
    checkOutput("stufferr_eop", eopTotal - baseE, 32'd0);

    // Reset after four data bits: outputs clear at once, then a clean packet.
    baseW = wrTotal;
    idleBits(2);
    sendSync();
    sendNrzi(1'b1);
    sendNrzi(1'b0);
    sendNrzi(1'b1);
    sendNrzi(1'b0);
    checkOutput("rst_mid_rcving_before", {31'h0, rcving}, 32'd1);
    n_rst = 1'b0;
    #1;
    checkOutput("rst_mid_rcving", {31'h0, rcving}, 32'd0);
    checkOutput("rst_mid_rcv_data", {24'h0, rcv_data}, 32'h0);
    checkOutput("rst_mid_r_error", {31'h0, r_error}, 32'd0);
    checkOutput("rst_mid_w_enable", {31'h0, w_enable}, 32'd0);
    checkOutput("rst_mid_eop_pulse", {31'h0, eop_pulse}, 32'd0);
    lineJ      = 1'b1;
    d_plus_in  = 1'b1;
    d_minus_in = 1'b0;
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    checkOutput("rst_mid_writes", wrTotal - baseW, 32'd0);
    idleBits(4);
    applyStimulus(vecs[0], 5);

    $display("== %0d vectors applied, %0d miscompares ==", vecApplied, miscompares);
    $finish;
  end

endmodule
